// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped data cache.
// Address split at default geometry: tag [15:4], index [3:2], offset [1:0].
package cache_pkg;

  localparam int LINES          = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int ADDR_W         = 16;
  localparam int WORD_W         = 16;
  localparam int INDEX_W        = $clog2(LINES);
  localparam int OFFSET_W       = $clog2(WORDS_PER_LINE);
  localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W         = WORDS_PER_LINE * WORD_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/cache_array.sv
// Tag/valid/dirty/data storage for the cache. Reads are combinational by index;
// word writes, line fills and dirty clears all target that same index.
module cache_array #(
  parameter int LINES    = cache_pkg::LINES,
  parameter int TAG_W    = cache_pkg::TAG_W,
  parameter int INDEX_W  = cache_pkg::INDEX_W,
  parameter int OFFSET_W = cache_pkg::OFFSET_W,
  parameter int LINE_W   = cache_pkg::LINE_W
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [INDEX_W-1:0]  index,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [LINE_W-1:0]   rd_line,
  input  logic                wr_en,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [15:0]         wr_data,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [LINE_W-1:0]   fill_line,
  input  logic                clr_dirty
);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [LINE_W-1:0] data_d [LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      data_d[index]  = fill_line;
      tag_d[index]   = fill_tag;
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
    end
    if (wr_en) begin
      data_d[index][{wr_offset, 4'b0000} +: 16] = wr_data;
      dirty_d[index] = 1'b1;
    end
    if (clr_dirty) begin
      dirty_d[index] = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: same-cycle hits, and on a
// miss an optional victim write-back, a full-line refill, then a replayed hit.
module data_cache #(
  parameter int LINES          = cache_pkg::LINES,
  parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           cpu_read,
  input  logic                           cpu_write,
  input  logic [15:0]                    cpu_address,
  input  logic [15:0]                    cpu_wdata,
  output logic [15:0]                    cpu_rdata,
  output logic                           cpu_stall,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [15:0]                    mem_address,
  output logic [WORDS_PER_LINE*16-1:0]   mem_wdata,
  input  logic [WORDS_PER_LINE*16-1:0]   mem_rdata,
  input  logic                           mem_ready,
  output logic [15:0]                    hit_count,
  output logic [15:0]                    miss_count
);

  localparam int INDEX_W  = $clog2(LINES);
  localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W    = 16 - INDEX_W - OFFSET_W;
  localparam int LINE_W   = WORDS_PER_LINE * 16;

  cache_pkg::state_e state_q, state_d;

  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [15:0]       mem_address_q, mem_address_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              replay_q, replay_d;
  logic [15:0]       hit_count_q, hit_count_d;
  logic [15:0]       miss_count_q, miss_count_d;

  logic [TAG_W-1:0]    cpu_tag;
  logic [INDEX_W-1:0]  cpu_index;
  logic [OFFSET_W-1:0] cpu_offset;
  logic                rd_valid, rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                req, idle, hit, hit_idle;

  assign cpu_tag    = cpu_address[15 -: TAG_W];
  assign cpu_index  = cpu_address[OFFSET_W +: INDEX_W];
  assign cpu_offset = cpu_address[OFFSET_W-1:0];

  assign req      = cpu_read | cpu_write;
  assign idle     = (state_q == cache_pkg::IDLE);
  assign hit      = req & rd_valid & (rd_tag == cpu_tag);
  assign hit_idle = idle & hit;

  cache_array #(
    .LINES    (LINES),
    .TAG_W    (TAG_W),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .LINE_W   (LINE_W)
  ) u_array (
    .Clk       (Clk),
    .Reset     (Reset),
    .index     (cpu_index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (hit_idle & cpu_write),
    .wr_offset (cpu_offset),
    .wr_data   (cpu_wdata),
    .fill_en   ((state_q == cache_pkg::ALLOCATE) & mem_ready),
    .fill_tag  (cpu_tag),
    .fill_line (mem_rdata),
    .clr_dirty ((state_q == cache_pkg::WRITEBACK) & mem_ready)
  );

  // A simultaneous read+write is a store, so no load data is returned for it.
  assign cpu_stall = ~idle | (req & ~hit);
  assign cpu_rdata = (hit_idle & cpu_read & ~cpu_write) ?
                     rd_line[{cpu_offset, 4'b0000} +: 16] : 16'h0000;

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    replay_d      = replay_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    case (state_q)
      cache_pkg::IDLE: begin
        if (hit) begin
          // The replayed access after a refill was already counted as a miss.
          if (!replay_q) hit_count_d = hit_count_q + 16'd1;
          replay_d = 1'b0;
        end else if (req) begin
          miss_count_d = miss_count_q + 16'd1;
          if (rd_valid && rd_dirty) begin
            state_d       = cache_pkg::WRITEBACK;
            mem_write_d   = 1'b1;
            mem_address_d = {rd_tag, cpu_index, {OFFSET_W{1'b0}}};
            mem_wdata_d   = rd_line;
          end else begin
            state_d       = cache_pkg::ALLOCATE;
            mem_read_d    = 1'b1;
            mem_address_d = {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};
          end
        end
      end
      cache_pkg::WRITEBACK: begin
        if (mem_ready) begin
          state_d       = cache_pkg::ALLOCATE;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
          mem_address_d = {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};
        end
      end
      cache_pkg::ALLOCATE: begin
        if (mem_ready) begin
          state_d    = cache_pkg::IDLE;
          mem_read_d = 1'b0;
          replay_d   = 1'b1;
        end
      end
      default: begin
        state_d     = cache_pkg::IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= cache_pkg::IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      replay_q      <= 1'b0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      replay_q      <= replay_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed, table-driven bench for data_cache with a behavioural line memory
// whose response delay is set per vector.
module tb_data_cache;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_address = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_stall, mem_read, mem_write;
  logic [15:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] hit_count, miss_count;

  data_cache dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rd, wr;
    logic [15:0] addr, wdata;
    int          delay;
    logic        chk_rd;
    logic [15:0] exp_rdata;
    int          exp_stall;
    logic [15:0] exp_hits, exp_misses;
    int          exp_fills;
    logic [15:0] exp_fill_addr;
    int          exp_wbs;
    logic [15:0] exp_wb_addr;
    logic [63:0] exp_wb_data;
  } vec_t;

  int n_vec = 0, n_fail = 0;
  int mem_delay = 2, wait_cnt = 0;
  int fill_cnt = 0, wb_cnt = 0;
  logic overlap = 1'b0;
  logic [15:0] last_fill_addr = '0, last_wb_addr = '0;
  logic [63:0] last_wb_data = '0;
  logic [63:0] wb_mem [logic [15:0]];
  vec_t vq[$];

  // Untouched memory: word k of line L is (L - 0x10) + k + 1, so line 0x10 = {4,3,2,1}.
  function automatic logic [63:0] line_of(logic [15:0] la);
    logic [15:0] b;
    if (wb_mem.exists(la)) return wb_mem[la];
    b = la - 16'h0010;
    return {b + 16'd4, b + 16'd3, b + 16'd2, b + 16'd1};
  endfunction

  function automatic vec_t mk(logic rd, logic wr, logic [15:0] addr, logic [15:0] wdata,
                              int delay, logic chk_rd, logic [15:0] exp_rdata, int exp_stall,
                              logic [15:0] exp_hits, logic [15:0] exp_misses,
                              int exp_fills, logic [15:0] exp_fill_addr,
                              int exp_wbs, logic [15:0] exp_wb_addr, logic [63:0] exp_wb_data);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.delay = delay;
    v.chk_rd = chk_rd; v.exp_rdata = exp_rdata; v.exp_stall = exp_stall;
    v.exp_hits = exp_hits; v.exp_misses = exp_misses;
    v.exp_fills = exp_fills; v.exp_fill_addr = exp_fill_addr;
    v.exp_wbs = exp_wbs; v.exp_wb_addr = exp_wb_addr; v.exp_wb_data = exp_wb_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: mem_ready pulses in the delay-th cycle a request is held.
  initial begin
    forever begin
      @(posedge Clk);
      #2;
      if (mem_read && mem_write) overlap = 1'b1;
      if (mem_read || mem_write) begin
        wait_cnt++;
        if (wait_cnt >= mem_delay) begin
          mem_ready = 1'b1;
          wait_cnt = 0;
          if (mem_write) begin
            wb_mem[mem_address] = mem_wdata;
            wb_cnt++;
            last_wb_addr = mem_address;
            last_wb_data = mem_wdata;
          end else begin
            mem_rdata = line_of(mem_address);
            fill_cnt++;
            last_fill_addr = mem_address;
          end
        end else begin
          mem_ready = 1'b0;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic run_vec(input int i, input vec_t v);
    int stalls, fills0, wbs0;
    string tag;
    tag = $sformatf("v%0d", i);
    fills0 = fill_cnt;
    wbs0 = wb_cnt;
    mem_delay = v.delay;
    stalls = 0;
    cpu_read = v.rd; cpu_write = v.wr; cpu_address = v.addr; cpu_wdata = v.wdata;
    #1;
    while (cpu_stall && stalls < 200) begin
      stalls++;
      @(posedge Clk);
      #3;
    end
    chk({tag, " stall_cycles"}, 64'(stalls), 64'(v.exp_stall));
    if (v.chk_rd) chk({tag, " cpu_rdata"}, 64'(cpu_rdata), 64'(v.exp_rdata));
    @(posedge Clk);
    #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    #2;
    chk({tag, " hit_count"}, 64'(hit_count), 64'(v.exp_hits));
    chk({tag, " miss_count"}, 64'(miss_count), 64'(v.exp_misses));
    chk({tag, " fills"}, 64'(fill_cnt - fills0), 64'(v.exp_fills));
    chk({tag, " writebacks"}, 64'(wb_cnt - wbs0), 64'(v.exp_wbs));
    if (v.exp_fills > 0) chk({tag, " fill_addr"}, 64'(last_fill_addr), 64'(v.exp_fill_addr));
    if (v.exp_wbs > 0) begin
      chk({tag, " wb_addr"}, 64'(last_wb_addr), 64'(v.exp_wb_addr));
      chk({tag, " wb_data"}, last_wb_data, v.exp_wb_data);
    end
  endtask

  initial begin
    //           rd wr addr      wdata    d  chk rdata     stall hit  miss  f fill_addr  w wb_addr   wb_data
    vq.push_back(mk(1, 0, 16'h0012, 16'h0000, 2, 1, 16'h0003,  3,  0, 1, 1, 16'h0010, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0011, 16'h0000, 2, 1, 16'h0002,  0,  1, 1, 0, 16'h0000, 0, 16'h0000, 64'h0));
    vq.push_back(mk(0, 1, 16'h0011, 16'hBEEF, 2, 0, 16'h0000,  0,  2, 1, 0, 16'h0000, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0051, 16'h0000, 2, 1, 16'h0042,  5,  2, 2, 1, 16'h0050, 1, 16'h0010, 64'h0004_0003_BEEF_0001));
    vq.push_back(mk(0, 1, 16'h0020, 16'h1234, 2, 0, 16'h0000,  3,  2, 3, 1, 16'h0020, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0020, 16'h0000, 2, 1, 16'h1234,  0,  3, 3, 0, 16'h0000, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0023, 16'h0000, 2, 1, 16'h0014,  0,  4, 3, 0, 16'h0000, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0010, 16'h0000, 2, 1, 16'h0001,  5,  4, 4, 1, 16'h0010, 1, 16'h0020, 64'h0014_0013_0012_1234));
    vq.push_back(mk(1, 0, 16'h0011, 16'h0000, 2, 1, 16'hBEEF,  0,  5, 4, 0, 16'h0000, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0016, 16'h0000, 2, 1, 16'h0007,  3,  5, 5, 1, 16'h0014, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 1, 16'h0017, 16'hAAAA, 2, 0, 16'h0000,  0,  6, 5, 0, 16'h0000, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0017, 16'h0000, 2, 1, 16'hAAAA,  0,  7, 5, 0, 16'h0000, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0008, 16'h0000, 1, 1, 16'hFFF9,  2,  7, 6, 1, 16'h0008, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0018, 16'h0000, 5, 1, 16'h0009,  6,  7, 7, 1, 16'h0018, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0029, 16'h0000,20, 1, 16'h001A, 21,  7, 8, 1, 16'h0028, 0, 16'h0000, 64'h0));
    vq.push_back(mk(0, 1, 16'h002A, 16'h5555, 2, 0, 16'h0000,  0,  8, 8, 0, 16'h0000, 0, 16'h0000, 64'h0));
    vq.push_back(mk(1, 0, 16'h0009, 16'h0000, 5, 1, 16'hFFFA, 11,  8, 9, 1, 16'h0008, 1, 16'h0028, 64'h001C_5555_001A_0019));

    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #2;
    chk("reset cpu_rdata", 64'(cpu_rdata), 64'h0);
    chk("reset cpu_stall", 64'(cpu_stall), 64'h0);
    chk("reset mem_read", 64'(mem_read), 64'h0);
    chk("reset mem_write", 64'(mem_write), 64'h0);
    chk("reset mem_address", 64'(mem_address), 64'h0);
    chk("reset mem_wdata", mem_wdata, 64'h0);
    chk("reset hit_count", 64'(hit_count), 64'h0);
    chk("reset miss_count", 64'(miss_count), 64'h0);

    foreach (vq[i]) run_vec(i, vq[i]);

    // Reset in the middle of a slow refill.
    mem_delay = 20;
    cpu_read = 1'b1; cpu_address = 16'h000C;
    repeat (3) begin
      @(posedge Clk);
      #3;
    end
    chk("midmiss mem_read before reset", 64'(mem_read), 64'h1);
    chk("midmiss stall before reset", 64'(cpu_stall), 64'h1);
    Reset = 1'b1;
    #1;
    chk("midmiss mem_read after reset", 64'(mem_read), 64'h0);
    chk("midmiss hit_count after reset", 64'(hit_count), 64'h0);
    chk("midmiss miss_count after reset", 64'(miss_count), 64'h0);
    chk("midmiss mem_address after reset", 64'(mem_address), 64'h0);
    cpu_read = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #3;
    run_vec(100, mk(1, 0, 16'h000C, 16'h0000, 2, 1, 16'hFFFD, 3, 0, 1, 1, 16'h000C, 0, 16'h0000, 64'h0));
    run_vec(101, mk(1, 0, 16'h0011, 16'h0000, 2, 1, 16'hBEEF, 3, 0, 2, 1, 16'h0010, 0, 16'h0000, 64'h0));

    chk("mem_read and mem_write overlap", 64'(overlap), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
